mem_cmd_splitter: RTL and testbench

- Accepts arbitrary-length memory commands (64-bit address, 32-bit byte length) and splits each into AXI-legal burst commands.
- Splitting rules: no 4 KiB crossing; at most MAX_BURST_BEATS beats of DATA_WIDTH per burst.
- Tracks the sub-commands of each parent command, merges their returned statuses, and emits one status per parent.
- Sits between the command sources (RDMA/TCP engines) and the datamover/AXI-MM front end.
- Generalises the fixed-width command/status streams to parametrised data width, burst size and outstanding depth.

---
 rtl/davos_mem_pkg.sv | 40 ++++
 rtl/mem_cmd_track_fifo.sv | 56 +++++
 rtl/mem_cmd_splitter.sv | 172 +++++++++++++++++
 tb/tb_mem_cmd_splitter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/davos_mem_pkg.sv
// Shared types and constants for the memory command path.
// Used by mem_cmd_splitter and its tracking FIFO.
package davos_mem_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int LEN_WIDTH  = 32;
  localparam int PAGE_BYTES = 4096;
  localparam int STS_WIDTH  = 8;
  localparam int CNT_WIDTH  = 21;

  localparam int STS_DECERR       = 0;
  localparam int STS_SLVERR       = 1;
  localparam int STS_OKAY_PARTIAL = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [LEN_WIDTH-1:0]  length;
  } mem_cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_SPLIT
  } split_state_e;

  // Largest legal burst at addr: bounded by remainder, burst cap, page end
  function automatic logic [LEN_WIDTH-1:0] burst_len(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [LEN_WIDTH-1:0]  rem,
    input logic [LEN_WIDTH-1:0]  max_bytes
  );
    logic [LEN_WIDTH-1:0] page_left;
    logic [LEN_WIDTH-1:0] len;
    page_left = LEN_WIDTH'(PAGE_BYTES) - LEN_WIDTH'(addr[11:0]);
    len = rem;
    if (max_bytes < len) len = max_bytes;
    if (page_left < len) len = page_left;
    return len;
  endfunction

endpackage

// File: rtl/mem_cmd_track_fifo.sv
// Tracking FIFO of per-parent sub-command counts.
// First-word-fall-through; simultaneous push and pop allowed.
module mem_cmd_track_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + AW'(1);
      if (w_rd) r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_cmd_splitter.sv
// Splits parent memory commands into AXI-legal bursts and merges statuses.
// Optional MEM_CMD_SPLITTER_STATS_EN adds saturating activity counters.
module mem_cmd_splitter
  import davos_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BURST_BEATS = 64,
  parameter int OUTSTANDING     = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [63:0] s_cmd_address,
  input  logic [31:0] s_cmd_length,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [63:0] m_cmd_address,
  output logic [31:0] m_cmd_length,
  input  logic        s_sts_valid,
  output logic        s_sts_ready,
  input  logic [7:0]  s_sts_data,
  output logic        m_sts_valid,
  input  logic        m_sts_ready,
  output logic [7:0]  m_sts_data
`ifdef MEM_CMD_SPLITTER_STATS_EN
  ,
  output logic [31:0] stat_cmd_cnt,
  output logic [31:0] stat_sub_cnt,
  output logic [15:0] stat_err_cnt
`endif
);

  localparam int MAX_BURST_BYTES = MAX_BURST_BEATS * DATA_WIDTH / 8;

  split_state_e          r_state;
  split_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_rem_len;
  logic [CNT_WIDTH-1:0]  r_sub_cnt;
  logic [LEN_WIDTH-1:0]  w_len;
  logic                  w_cmd_hs;
  logic                  w_sub_hs;
  logic                  w_push;
  logic [CNT_WIDTH-1:0]  w_push_data;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_WIDTH-1:0]  r_rcv;
  logic [CNT_WIDTH-1:0]  w_rcv_inc;
  logic [STS_WIDTH-1:0]  r_acc;
  logic                  r_sts_valid;
  logic                  w_sts_hs;
  logic                  w_msts_hs;

  assign w_len = burst_len(r_cur_addr, r_rem_len,
                           LEN_WIDTH'(MAX_BURST_BYTES));

  assign s_cmd_ready   = aresetn && (r_state == ST_IDLE) && !w_full;
  assign m_cmd_valid   = (r_state == ST_SPLIT);
  assign m_cmd_address = r_cur_addr;
  assign m_cmd_length  = w_len;
  assign w_cmd_hs      = s_cmd_valid && s_cmd_ready;
  assign w_sub_hs      = m_cmd_valid && m_cmd_ready;

  // Split FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and tracking-FIFO push on parent completion
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          if (s_cmd_length == '0) w_push = 1'b1;
          else                    w_state_nxt = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        if (w_sub_hs && (r_rem_len == w_len)) begin
          w_push      = 1'b1;
          w_push_data = r_sub_cnt + CNT_WIDTH'(1);
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Current address, remaining length and sub-command count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cur_addr <= '0;
      r_rem_len  <= '0;
      r_sub_cnt  <= '0;
    end else if (w_cmd_hs) begin
      r_cur_addr <= s_cmd_address;
      r_rem_len  <= s_cmd_length;
      r_sub_cnt  <= '0;
    end else if (w_sub_hs) begin
      r_cur_addr <= r_cur_addr + ADDR_WIDTH'(w_len);
      r_rem_len  <= r_rem_len - w_len;
      r_sub_cnt  <= r_sub_cnt + CNT_WIDTH'(1);
    end
  end

  mem_cmd_track_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (CNT_WIDTH)
  ) u_track (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_sts_ready = !w_empty && !r_sts_valid && (w_head != '0);
  assign w_sts_hs    = s_sts_valid && s_sts_ready;
  assign w_msts_hs   = r_sts_valid && m_sts_ready;
  assign w_pop       = w_msts_hs;
  assign w_rcv_inc   = r_rcv + CNT_WIDTH'(1);
  assign m_sts_valid = r_sts_valid;
  assign m_sts_data  = r_acc;

  // Merge sub-statuses of the head parent into one status
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rcv       <= '0;
      r_acc       <= '0;
      r_sts_valid <= 1'b0;
    end else if (w_msts_hs) begin
      r_rcv       <= '0;
      r_acc       <= '0;
      r_sts_valid <= 1'b0;
    end else if (w_sts_hs) begin
      r_acc <= r_acc | s_sts_data;
      r_rcv <= w_rcv_inc;
      if (w_rcv_inc == w_head) r_sts_valid <= 1'b1;
    end else if (!w_empty && !r_sts_valid && (w_head == '0)) begin
      r_sts_valid <= 1'b1;
    end
  end

`ifdef MEM_CMD_SPLITTER_STATS_EN
  // Saturating parent, sub-command and error counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_cmd_cnt <= '0;
      stat_sub_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (w_cmd_hs && (stat_cmd_cnt != '1))
        stat_cmd_cnt <= stat_cmd_cnt + 32'd1;
      if (w_sub_hs && (stat_sub_cnt != '1))
        stat_sub_cnt <= stat_sub_cnt + 32'd1;
      if (w_msts_hs && (r_acc != '0) && (stat_err_cnt != '1))
        stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_cmd_splitter.sv
// Scoreboard bench for mem_cmd_splitter.
// Directed cases plus randomized traffic against a split/merge model.
module tb_mem_cmd_splitter;

  localparam int DW    = 512;
  localparam int BEATS = 64;
  localparam int OUTS  = 2;
  localparam longint unsigned MAXB = BEATS * DW / 8;

  typedef struct {
    logic [63:0] a;
    logic [31:0] l;
  } sub_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [63:0] s_cmd_address = '0;
  logic [31:0] s_cmd_length = '0;
  logic        m_cmd_valid;
  logic        m_cmd_ready = 1'b0;
  logic [63:0] m_cmd_address;
  logic [31:0] m_cmd_length;
  logic        s_sts_valid = 1'b0;
  logic        s_sts_ready;
  logic [7:0]  s_sts_data = '0;
  logic        m_sts_valid;
  logic        m_sts_ready = 1'b0;
  logic [7:0]  m_sts_data;

  always #5 aclk = ~aclk;

  mem_cmd_splitter #(
    .DATA_WIDTH      (DW),
    .MAX_BURST_BEATS (BEATS),
    .OUTSTANDING     (OUTS)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_cmd_valid   (s_cmd_valid),
    .s_cmd_ready   (s_cmd_ready),
    .s_cmd_address (s_cmd_address),
    .s_cmd_length  (s_cmd_length),
    .m_cmd_valid   (m_cmd_valid),
    .m_cmd_ready   (m_cmd_ready),
    .m_cmd_address (m_cmd_address),
    .m_cmd_length  (m_cmd_length),
    .s_sts_valid   (s_sts_valid),
    .s_sts_ready   (s_sts_ready),
    .s_sts_data    (s_sts_data),
    .m_sts_valid   (m_sts_valid),
    .m_sts_ready   (m_sts_ready),
    .m_sts_data    (m_sts_data)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_sts_seen = 0;
  int rdy_mode = 0;
  int sts_rdy_mode = 0;
  bit sts_en = 1'b1;
  bit sts_gap = 1'b0;

  sub_t       exp_cmd[$];
  sub_t       log_cmd[$];
  logic [7:0] exp_sts[$];
  logic [7:0] log_sts[$];
  logic [7:0] sts_src[$];
  logic [7:0] sts_pat[$];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: carve a parent into bursts by page end and burst cap
  function automatic int model_split(input logic [63:0] a,
                                     input logic [31:0] l);
    longint unsigned rem, len, page_left;
    logic [63:0] cur;
    int n;
    rem = l;
    cur = a;
    n = 0;
    while (rem > 0) begin
      page_left = 4096 - (cur % 4096);
      len = rem;
      if (len > MAXB) len = MAXB;
      if (len > page_left) len = page_left;
      exp_cmd.push_back('{cur, len[31:0]});
      cur = cur + len;
      rem = rem - len;
      n++;
    end
    return n;
  endfunction

  task automatic issue_model(input logic [63:0] a, input logic [31:0] l);
    int n;
    logic [7:0] s, merged;
    n = model_split(a, l);
    merged = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (sts_pat.size() > 0) s = sts_pat.pop_front();
      else if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(1, 255));
      else s = 8'h00;
      sts_src.push_back(s);
      merged = merged | s;
    end
    exp_sts.push_back(merged);
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l);
    int t;
    t = 0;
    @(posedge aclk); #1;
    s_cmd_valid = 1'b1;
    s_cmd_address = a;
    s_cmd_length = l;
    forever begin
      @(negedge aclk);
      if (s_cmd_ready || t >= 3000) break;
      t++;
    end
    chk("cmd_accept", s_cmd_ready, 1);
    if (s_cmd_ready) issue_model(a, l);
    @(posedge aclk); #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_cmd.size() + exp_sts.size()) != 0 && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    chk("drain", exp_cmd.size() + exp_sts.size(), 0);
  endtask

  // Downstream ready generators
  initial forever begin
    @(posedge aclk); #1;
    case (rdy_mode)
      0:       m_cmd_ready = 1'b1;
      1:       m_cmd_ready = 1'($urandom_range(0, 1));
      default: m_cmd_ready = 1'b0;
    endcase
    m_sts_ready = (sts_rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Sub-status source
  initial forever begin
    @(posedge aclk); #1;
    if (aresetn && sts_en && sts_src.size() > 0 &&
        (!sts_gap || $urandom_range(0, 2) != 0)) begin
      s_sts_valid = 1'b1;
      s_sts_data = sts_src[0];
    end else begin
      s_sts_valid = 1'b0;
      s_sts_data = 8'h00;
    end
  end

  // Monitor: compares presented outputs against the scoreboard heads
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_sts_valid && s_sts_ready && sts_src.size() > 0)
        void'(sts_src.pop_front());
      if (m_cmd_valid) begin
        if (exp_cmd.size() == 0) begin
          chk("m_cmd_unexpected", m_cmd_valid, 0);
        end else begin
          chk("m_cmd_addr", m_cmd_address, exp_cmd[0].a);
          chk("m_cmd_len", m_cmd_length, exp_cmd[0].l);
          if (m_cmd_ready) begin
            log_cmd.push_back('{m_cmd_address, m_cmd_length});
            void'(exp_cmd.pop_front());
          end
        end
      end
      if (m_sts_valid && m_sts_ready) begin
        n_sts_seen++;
        log_sts.push_back(m_sts_data);
        if (exp_sts.size() == 0) chk("m_sts_unexpected", m_sts_valid, 0);
        else chk("m_sts_data", m_sts_data, exp_sts.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    bit seen;
    logic [63:0] a;
    logic [31:0] l;

    repeat (3) @(negedge aclk);
    chk("rst_s_cmd_ready", s_cmd_ready, 0);
    chk("rst_m_cmd_valid", m_cmd_valid, 0);
    chk("rst_s_sts_ready", s_sts_ready, 0);
    chk("rst_m_sts_valid", m_sts_valid, 0);
    chk("rst_m_cmd_addr", m_cmd_address, 0);
    chk("rst_m_cmd_len", m_cmd_length, 0);
    chk("rst_m_sts_data", m_sts_data, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    log_cmd.delete(); log_sts.delete();
    sts_pat.push_back(8'h00);
    send_cmd(64'h1000, 32'd64);
    @(negedge aclk);
    chk("t1_latency", m_cmd_valid, 1);
    drain();
    chk("t1_count", log_cmd.size(), 1);
    chk("t1_addr", log_cmd[0].a, 64'h1000);
    chk("t1_len", log_cmd[0].l, 64);
    chk("t1_sts", log_sts[0], 8'h00);

    log_cmd.delete(); log_sts.delete();
    send_cmd(64'h0FC0, 32'd256);
    @(negedge aclk);
    chk("t2_first_addr", m_cmd_address, 64'h0FC0);
    chk("t2_first_len", m_cmd_length, 64);
    @(negedge aclk);
    chk("t2_b2b_valid", m_cmd_valid, 1);
    chk("t2_second_addr", m_cmd_address, 64'h1000);
    chk("t2_second_len", m_cmd_length, 192);
    drain();

    log_cmd.delete(); log_sts.delete();
    sts_pat.push_back(8'h00);
    sts_pat.push_back(8'h02);
    sts_pat.push_back(8'h00);
    send_cmd(64'h0, 32'd10000);
    drain();
    chk("t3_count", log_cmd.size(), 3);
    chk("t3_a0", log_cmd[0].a, 0);
    chk("t3_l0", log_cmd[0].l, 4096);
    chk("t3_a1", log_cmd[1].a, 4096);
    chk("t3_l1", log_cmd[1].l, 4096);
    chk("t3_a2", log_cmd[2].a, 8192);
    chk("t3_l2", log_cmd[2].l, 1808);
    chk("t3_sts_count", log_sts.size(), 1);
    chk("t3_sts", log_sts[0], 8'h02);

    log_cmd.delete(); log_sts.delete();
    send_cmd(64'h3000, 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      if (m_sts_valid && m_sts_data == 8'h00) seen = 1'b1;
    end
    chk("t4_zero_sts", seen, 1);
    drain();
    chk("t4_no_m_cmd", log_cmd.size(), 0);

    sts_en = 1'b0;
    send_cmd(64'h4000, 32'd64);
    send_cmd(64'h5000, 32'd64);
    repeat (3) begin
      @(negedge aclk);
      chk("bp_ready_low", s_cmd_ready, 0);
    end
    rdy_mode = 2;
    base = n_sts_seen;
    fork
      begin
        repeat (10) @(posedge aclk);
        #1 sts_en = 1'b1;
      end
      send_cmd(64'h6000, 32'd64);
    join
    chk("bp_order", (n_sts_seen > base), 1);
    repeat (5) begin
      @(negedge aclk);
      chk("stall_valid", m_cmd_valid, 1);
      chk("stall_addr", m_cmd_address, 64'h6000);
      chk("stall_len", m_cmd_length, 64);
    end
    rdy_mode = 0;
    drain();

    rdy_mode = 1;
    sts_rdy_mode = 1;
    sts_gap = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {32'($urandom()), 32'($urandom())};
      case ($urandom_range(0, 2))
        0: ;
        1: a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
        default: a = 64'hFFFF_FFFF_FFFF_E000 + 64'($urandom_range(0, 8191));
      endcase
      case ($urandom_range(0, 3))
        0: l = 32'($urandom_range(1, 300));
        1: l = 32'($urandom_range(1, 20000));
        2: l = 32'd0;
        default: l = 32'd4096;
      endcase
      send_cmd(a, l);
    end
    drain();

    rdy_mode = 0;
    sts_rdy_mode = 0;
    sts_gap = 1'b0;
    sts_en = 1'b0;
    send_cmd(64'h0, 32'd12288);
    @(negedge aclk);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_m_cmd_valid", m_cmd_valid, 0);
    chk("mid_rst_m_sts_valid", m_sts_valid, 0);
    chk("mid_rst_s_cmd_ready", s_cmd_ready, 0);
    chk("mid_rst_s_sts_ready", s_sts_ready, 0);
    exp_cmd.delete();
    exp_sts.delete();
    sts_src.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    sts_en = 1'b1;
    log_cmd.delete(); log_sts.delete();
    send_cmd(64'h2000, 32'd128);
    drain();
    repeat (10) @(negedge aclk);
    chk("t6_count", log_cmd.size(), 1);
    chk("t6_addr", log_cmd[0].a, 64'h2000);
    chk("t6_len", log_cmd[0].l, 128);
    chk("t6_sts_count", log_sts.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
